// File: rtl/dag_pkg.sv
// Shared constants for the data address generator: ureg group codes,
// default widths and ureg address field positions.
package dag_pkg;

  localparam int DMA_SIZE_DEF = 16;
  localparam int NREG_DEF     = 4;

  typedef enum logic [1:0] {
    GRP_I = 2'b00,
    GRP_M = 2'b01,
    GRP_L = 2'b10,
    GRP_B = 2'b11
  } dag_grp_e;

  localparam int UADD_GRP_HI = 3;
  localparam int UADD_GRP_LO = 2;
  localparam int UADD_IDX_HI = 1;
  localparam int UADD_IDX_LO = 0;

endpackage

// File: rtl/dag_if.sv
// Sequencer / bus-connect side of the DAG. ps_dg_brev exists only when
// DAG_BITREV_EN is defined.
interface dag_if #(parameter int DMA_SIZE = dag_pkg::DMA_SIZE_DEF);

  logic                ps_dg_en;
  logic                ps_dg_pre;
  logic [1:0]          ps_dg_iadd;
  logic [1:0]          ps_dg_madd;
  logic                ps_dg_wrt_en;
  logic [3:0]          ps_dg_wrt_add;
  logic [3:0]          ps_dg_rd_add;
  logic [DMA_SIZE-1:0] bc_dt;
  logic [DMA_SIZE-1:0] dg_dm_add;
  logic [DMA_SIZE-1:0] dg_bc_dt;
`ifdef DAG_BITREV_EN
  logic                ps_dg_brev;

  modport master (
    output ps_dg_en, ps_dg_pre, ps_dg_iadd, ps_dg_madd, ps_dg_wrt_en,
           ps_dg_wrt_add, ps_dg_rd_add, bc_dt, ps_dg_brev,
    input  dg_dm_add, dg_bc_dt
  );
  modport slave (
    input  ps_dg_en, ps_dg_pre, ps_dg_iadd, ps_dg_madd, ps_dg_wrt_en,
           ps_dg_wrt_add, ps_dg_rd_add, bc_dt, ps_dg_brev,
    output dg_dm_add, dg_bc_dt
  );
`else
  modport master (
    output ps_dg_en, ps_dg_pre, ps_dg_iadd, ps_dg_madd, ps_dg_wrt_en,
           ps_dg_wrt_add, ps_dg_rd_add, bc_dt,
    input  dg_dm_add, dg_bc_dt
  );
  modport slave (
    input  ps_dg_en, ps_dg_pre, ps_dg_iadd, ps_dg_madd, ps_dg_wrt_en,
           ps_dg_wrt_add, ps_dg_rd_add, bc_dt,
    output dg_dm_add, dg_bc_dt
  );
`endif

endinterface

// File: rtl/dag_circ_add.sv
// Combinational modulo adder: next index from I + M, wrapped into the
// circular buffer [B, B+L) when L is non-zero.
module dag_circ_add #(
  parameter int DMA_SIZE = dag_pkg::DMA_SIZE_DEF
) (
  input  logic [DMA_SIZE-1:0] i_i,
  input  logic [DMA_SIZE-1:0] m_i,
  input  logic [DMA_SIZE-1:0] l_i,
  input  logic [DMA_SIZE-1:0] b_i,
  output logic [DMA_SIZE-1:0] next_o
);

  logic                m_neg;
  logic [DMA_SIZE:0]   sum;
  logic [DMA_SIZE:0]   lim;
  logic                below_b;

  always_comb begin
    m_neg   = m_i[DMA_SIZE-1];
    sum     = {1'b0, i_i} + {m_neg, m_i};
    lim     = {1'b0, b_i} + {1'b0, l_i};
    // with negative M the top sum bit is set only when I+M went below zero
    below_b = sum[DMA_SIZE] | (sum[DMA_SIZE-1:0] < b_i);
    next_o  = sum[DMA_SIZE-1:0];
    if (l_i != '0) begin
      if (!m_neg && (sum >= lim))
        next_o = sum[DMA_SIZE-1:0] - l_i;
      else if (m_neg && below_b)
        next_o = sum[DMA_SIZE-1:0] + l_i;
    end
  end

endmodule

// File: rtl/dag_addr_gen.sv
// Data address generator: four I/M/L/B sets, pre/post-modify, circular
// buffers, ureg access. DAG_BITREV_EN adds bit-reversed addressing on I0.
module dag_addr_gen
  import dag_pkg::*;
#(
  parameter int DMA_SIZE = DMA_SIZE_DEF,
  parameter int NREG     = NREG_DEF
) (
  input  logic clk,
  input  logic reset,
  dag_if.slave bus
);

  logic [DMA_SIZE-1:0] i_q [NREG];
  logic [DMA_SIZE-1:0] i_d [NREG];
  logic [DMA_SIZE-1:0] m_q [NREG];
  logic [DMA_SIZE-1:0] m_d [NREG];
  logic [DMA_SIZE-1:0] l_q [NREG];
  logic [DMA_SIZE-1:0] l_d [NREG];
  logic [DMA_SIZE-1:0] b_q [NREG];
  logic [DMA_SIZE-1:0] b_d [NREG];
  logic [DMA_SIZE-1:0] add_q, add_d;
  logic [DMA_SIZE-1:0] rd_q, rd_d;
  logic [DMA_SIZE-1:0] next_idx, issue_add;
  dag_grp_e            wr_grp, rd_grp;
  logic [1:0]          wr_idx, rd_idx;

  dag_circ_add #(.DMA_SIZE(DMA_SIZE)) u_circ (
    .i_i    (i_q[bus.ps_dg_iadd]),
    .m_i    (m_q[bus.ps_dg_madd]),
    .l_i    (l_q[bus.ps_dg_iadd]),
    .b_i    (b_q[bus.ps_dg_iadd]),
    .next_o (next_idx)
  );

  always_comb begin
    issue_add = bus.ps_dg_pre ? next_idx : i_q[bus.ps_dg_iadd];
`ifdef DAG_BITREV_EN
    if (bus.ps_dg_brev && (bus.ps_dg_iadd == 2'd0)) begin
      for (int k = 0; k < DMA_SIZE; k++)
        issue_add[k] = (bus.ps_dg_pre ? next_idx[DMA_SIZE-1-k] : i_q[0][DMA_SIZE-1-k]);
    end
`endif
    add_d = bus.ps_dg_en ? issue_add : add_q;
  end

  // post-modify update first so a same-cycle ureg write to that I wins
  always_comb begin
    wr_grp = dag_grp_e'(bus.ps_dg_wrt_add[UADD_GRP_HI:UADD_GRP_LO]);
    wr_idx = bus.ps_dg_wrt_add[UADD_IDX_HI:UADD_IDX_LO];
    i_d = i_q;
    m_d = m_q;
    l_d = l_q;
    b_d = b_q;
    if (bus.ps_dg_en && !bus.ps_dg_pre)
      i_d[bus.ps_dg_iadd] = next_idx;
    if (bus.ps_dg_wrt_en) begin
      case (wr_grp)
        GRP_I: i_d[wr_idx] = bus.bc_dt;
        GRP_M: m_d[wr_idx] = bus.bc_dt;
        GRP_L: l_d[wr_idx] = bus.bc_dt;
        GRP_B: begin
          b_d[wr_idx] = bus.bc_dt;
          i_d[wr_idx] = bus.bc_dt;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_grp = dag_grp_e'(bus.ps_dg_rd_add[UADD_GRP_HI:UADD_GRP_LO]);
    rd_idx = bus.ps_dg_rd_add[UADD_IDX_HI:UADD_IDX_LO];
    rd_d   = '0;
    case (rd_grp)
      GRP_I:   rd_d = i_q[rd_idx];
      GRP_M:   rd_d = m_q[rd_idx];
      GRP_L:   rd_d = l_q[rd_idx];
      GRP_B:   rd_d = b_q[rd_idx];
      default: rd_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NREG; k++) begin
        i_q[k] <= '0;
        m_q[k] <= '0;
        l_q[k] <= '0;
        b_q[k] <= '0;
      end
      add_q <= '0;
      rd_q  <= '0;
    end else begin
      for (int k = 0; k < NREG; k++) begin
        i_q[k] <= i_d[k];
        m_q[k] <= m_d[k];
        l_q[k] <= l_d[k];
        b_q[k] <= b_d[k];
      end
      add_q <= add_d;
      rd_q  <= rd_d;
    end
  end

  assign bus.dg_dm_add = add_q;
  assign bus.dg_bc_dt  = rd_q;

endmodule

// File: tb/tb_dag_addr_gen.sv
// Directed plus randomized bench for dag_addr_gen against an arithmetic
// reference model; define DAG_BITREV_EN to cover bit-reversed addressing.
module tb_dag_addr_gen;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  dag_if #(.DMA_SIZE(16)) bus ();

  dag_addr_gen #(.DMA_SIZE(16), .NREG(4)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // reference register file and expected outputs
  logic [15:0] mi [4];
  logic [15:0] mm [4];
  logic [15:0] ml [4];
  logic [15:0] mb [4];
  logic [15:0] exp_add;
  logic [15:0] exp_rd;

  task automatic chk_val(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %04h expected %04h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      mi[k] = '0; mm[k] = '0; ml[k] = '0; mb[k] = '0;
    end
    exp_add = '0;
    exp_rd  = '0;
  endtask

  function automatic logic [15:0] reg_read(input logic [3:0] a);
    case (a[3:2])
      2'b00:   return mi[a[1:0]];
      2'b01:   return mm[a[1:0]];
      2'b10:   return ml[a[1:0]];
      default: return mb[a[1:0]];
    endcase
  endfunction

  task automatic model_step();
    int          s;
    logic [15:0] iv, mv, lv, bv, nxt, a;
    exp_rd = reg_read(bus.ps_dg_rd_add);
    if (bus.ps_dg_en) begin
      iv = mi[bus.ps_dg_iadd];
      mv = mm[bus.ps_dg_madd];
      lv = ml[bus.ps_dg_iadd];
      bv = mb[bus.ps_dg_iadd];
      s  = int'(iv) + int'($signed(mv));
      if (lv != 0) begin
        if (!mv[15] && s >= int'(bv) + int'(lv)) s = s - int'(lv);
        else if (mv[15] && s < int'(bv))         s = s + int'(lv);
      end
      nxt = s[15:0];
      a   = bus.ps_dg_pre ? nxt : iv;
`ifdef DAG_BITREV_EN
      if (bus.ps_dg_brev && bus.ps_dg_iadd == 2'd0) a = {<<{a}};
`endif
      exp_add = a;
      if (!bus.ps_dg_pre) mi[bus.ps_dg_iadd] = nxt;
    end
    if (bus.ps_dg_wrt_en) begin
      case (bus.ps_dg_wrt_add[3:2])
        2'b00: mi[bus.ps_dg_wrt_add[1:0]] = bus.bc_dt;
        2'b01: mm[bus.ps_dg_wrt_add[1:0]] = bus.bc_dt;
        2'b10: ml[bus.ps_dg_wrt_add[1:0]] = bus.bc_dt;
        default: begin
          mb[bus.ps_dg_wrt_add[1:0]] = bus.bc_dt;
          mi[bus.ps_dg_wrt_add[1:0]] = bus.bc_dt;
        end
      endcase
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk_val("dm_add_model", bus.dg_dm_add, exp_add);
    chk_val("bc_dt_model", bus.dg_bc_dt, exp_rd);
  endtask

  task automatic idle();
    bus.ps_dg_en = 1'b0; bus.ps_dg_pre = 1'b0; bus.ps_dg_wrt_en = 1'b0;
`ifdef DAG_BITREV_EN
    bus.ps_dg_brev = 1'b0;
`endif
  endtask

  task automatic ureg_wr(input logic [3:0] a, input logic [15:0] d);
    idle();
    bus.ps_dg_wrt_en = 1'b1; bus.ps_dg_wrt_add = a; bus.bc_dt = d;
    cyc();
    idle();
  endtask

  task automatic gen(input logic [1:0] ia, input logic [1:0] ma, input logic pre);
    idle();
    bus.ps_dg_en = 1'b1; bus.ps_dg_iadd = ia; bus.ps_dg_madd = ma; bus.ps_dg_pre = pre;
    cyc();
    idle();
  endtask

  task automatic rd(input logic [3:0] a);
    idle();
    bus.ps_dg_rd_add = a;
    cyc();
  endtask

  initial begin
    model_reset();
    idle();
    bus.ps_dg_iadd = '0; bus.ps_dg_madd = '0;
    bus.ps_dg_wrt_add = '0; bus.ps_dg_rd_add = '0; bus.bc_dt = '0;
    repeat (2) @(negedge clk);
    chk_val("rst_dm_add", bus.dg_dm_add, 16'h0000);
    chk_val("rst_bc_dt", bus.dg_bc_dt, 16'h0000);
    reset = 1'b0;
    cyc();

    // linear post-modify
    ureg_wr(4'h0, 16'h0010);
    ureg_wr(4'h4, 16'h0002);
    gen(2'd0, 2'd0, 1'b0); chk_val("lin_a0", bus.dg_dm_add, 16'h0010);
    gen(2'd0, 2'd0, 1'b0); chk_val("lin_a1", bus.dg_dm_add, 16'h0012);
    gen(2'd0, 2'd0, 1'b0); chk_val("lin_a2", bus.dg_dm_add, 16'h0014);
    rd(4'h0);              chk_val("lin_i0", bus.dg_bc_dt, 16'h0016);
    cyc();                 chk_val("hold", bus.dg_dm_add, 16'h0014);

    // pre-modify with negative M
    ureg_wr(4'h1, 16'h0100);
    ureg_wr(4'h5, 16'hFFFF);
    gen(2'd1, 2'd1, 1'b1); chk_val("pre_add", bus.dg_dm_add, 16'h00FF);
    rd(4'h1);              chk_val("pre_i1", bus.dg_bc_dt, 16'h0100);

    // circular buffer
    ureg_wr(4'hE, 16'h0020);
    rd(4'h2);              chk_val("b_loads_i", bus.dg_bc_dt, 16'h0020);
    ureg_wr(4'hA, 16'h0005);
    ureg_wr(4'h6, 16'h0002);
    gen(2'd2, 2'd2, 1'b0); chk_val("circ0", bus.dg_dm_add, 16'h0020);
    gen(2'd2, 2'd2, 1'b0); chk_val("circ1", bus.dg_dm_add, 16'h0022);
    gen(2'd2, 2'd2, 1'b0); chk_val("circ2", bus.dg_dm_add, 16'h0024);
    gen(2'd2, 2'd2, 1'b0); chk_val("circ3", bus.dg_dm_add, 16'h0021);
    gen(2'd2, 2'd2, 1'b0); chk_val("circ4", bus.dg_dm_add, 16'h0023);
    ureg_wr(4'h2, 16'h0021);
    ureg_wr(4'h6, 16'hFFFE);
    gen(2'd2, 2'd2, 1'b0); chk_val("circ_neg_a", bus.dg_dm_add, 16'h0021);
    rd(4'h2);              chk_val("circ_neg_i", bus.dg_bc_dt, 16'h0024);

    // ureg write collides with post-modify of the same I
    ureg_wr(4'h3, 16'h0010);
    ureg_wr(4'h7, 16'h0001);
    bus.ps_dg_en = 1'b1; bus.ps_dg_pre = 1'b0; bus.ps_dg_iadd = 2'd3; bus.ps_dg_madd = 2'd3;
    bus.ps_dg_wrt_en = 1'b1; bus.ps_dg_wrt_add = 4'h3; bus.bc_dt = 16'h0050;
    cyc();                 chk_val("coll_add", bus.dg_dm_add, 16'h0010);
    rd(4'h3);              chk_val("coll_i3", bus.dg_bc_dt, 16'h0050);

    // async reset between edges
    gen(2'd0, 2'd0, 1'b0);
    bus.ps_dg_en = 1'b1; bus.ps_dg_rd_add = 4'h0;
    #2 reset = 1'b1;
    #1;
    chk_val("arst_dm_add", bus.dg_dm_add, 16'h0000);
    chk_val("arst_bc_dt", bus.dg_bc_dt, 16'h0000);
    model_reset();
    idle();
    @(negedge clk);
    reset = 1'b0;
    gen(2'd0, 2'd0, 1'b0); chk_val("post_rst", bus.dg_dm_add, 16'h0000);

`ifdef DAG_BITREV_EN
    ureg_wr(4'h0, 16'h0001);
    ureg_wr(4'h4, 16'h0000);
    bus.ps_dg_en = 1'b1; bus.ps_dg_iadd = 2'd0; bus.ps_dg_madd = 2'd0; bus.ps_dg_brev = 1'b1;
    cyc();                 chk_val("brev", bus.dg_dm_add, 16'h8000);
    idle();
`endif

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      bus.ps_dg_en      = ($urandom_range(0, 2) != 0);
      bus.ps_dg_pre     = $urandom_range(0, 1);
      bus.ps_dg_iadd    = 2'($urandom_range(0, 3));
      bus.ps_dg_madd    = 2'($urandom_range(0, 3));
      bus.ps_dg_wrt_en  = ($urandom_range(0, 2) == 0);
      bus.ps_dg_wrt_add = 4'($urandom_range(0, 15));
      bus.ps_dg_rd_add  = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0:       bus.bc_dt = 16'($urandom);
        1:       bus.bc_dt = 16'($urandom_range(0, 8));
        2:       bus.bc_dt = 16'h0000 - 16'($urandom_range(1, 8));
        default: bus.bc_dt = 16'($urandom_range(16'h0020, 16'h0040));
      endcase
`ifdef DAG_BITREV_EN
      bus.ps_dg_brev    = $urandom_range(0, 1);
`endif
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
